// File: rtl/inst_fetcher.sv
// Instruction fetcher: one-outstanding fetch FSM feeding a small circular instruction queue.
// Optional macro IFETCH_JAL_REDIRECT_EN follows JAL targets at fetch time instead of pc+4.
module inst_fetcher #(
    parameter int unsigned IQ_DEPTH_LOG = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic [31:0] rob_new_pc,
    output logic [31:0] pc,
    output logic        start_fetch,
    input  logic        fetch_ready,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int unsigned Depth = 1 << IQ_DEPTH_LOG;
    localparam logic [IQ_DEPTH_LOG:0]   DepthCnt = (IQ_DEPTH_LOG + 1)'(Depth);
    localparam logic [IQ_DEPTH_LOG:0]   CntOne   = (IQ_DEPTH_LOG + 1)'(1);
    localparam logic [IQ_DEPTH_LOG-1:0] PtrOne   = IQ_DEPTH_LOG'(1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e                  state_q;
    logic                    start_fetch_q;
    logic [31:0]             pc_q;
    logic [IQ_DEPTH_LOG-1:0] head_q;
    logic [IQ_DEPTH_LOG-1:0] tail_q;
    logic [IQ_DEPTH_LOG:0]   count_q;
    logic [31:0]             iq_inst_q [Depth];
    logic [31:0]             iq_pc_q   [Depth];

    logic        push;
    logic        pop;
    logic [31:0] next_pc;

    // Only a response matching the outstanding request is accepted; stale words are dropped.
    assign push = (state_q == StWait) && fetch_ready && (inst_addr == pc_q);
    assign pop  = dec_valid && dec_ready;

`ifdef IFETCH_JAL_REDIRECT_EN
    logic [31:0] jal_imm;
    assign jal_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign next_pc = (inst[6:0] == 7'b1101111) ? inst_addr + jal_imm : pc_q + 32'd4;
`else
    assign next_pc = pc_q + 32'd4;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StIdle;
            start_fetch_q <= 1'b0;
            pc_q          <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                state_q       <= StIdle;
                start_fetch_q <= 1'b0;
                pc_q          <= rob_new_pc;
                head_q        <= '0;
                tail_q        <= '0;
                count_q       <= '0;
            end else begin
                if (pop) begin
                    head_q <= head_q + PtrOne;
                end
                if (push) begin
                    tail_q <= tail_q + PtrOne;
                end
                if (push && !pop) begin
                    count_q <= count_q + CntOne;
                end else if (pop && !push) begin
                    count_q <= count_q - CntOne;
                end
                unique case (state_q)
                    StIdle: begin
                        if (count_q < DepthCnt) begin
                            state_q       <= StWait;
                            start_fetch_q <= 1'b1;
                        end
                    end
                    StWait: begin
                        if (push) begin
                            state_q       <= StIdle;
                            start_fetch_q <= 1'b0;
                            pc_q          <= next_pc;
                        end
                    end
                    default: begin
                        state_q       <= StIdle;
                        start_fetch_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear_up && push) begin
            iq_inst_q[tail_q] <= inst;
            iq_pc_q[tail_q]   <= inst_addr;
        end
    end

    assign pc          = pc_q;
    assign start_fetch = start_fetch_q;
    assign dec_valid   = (count_q != '0);
    assign dec_inst    = dec_valid ? iq_inst_q[head_q] : '0;
    assign dec_pc      = dec_valid ? iq_pc_q[head_q]   : '0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed scenarios plus randomized traffic vs a queue model.
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic [31:0] rob_new_pc;
    logic [31:0] pc;
    logic        start_fetch;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IFETCH_JAL_REDIRECT_EN
    localparam bit JalEn = 1'b1;
`else
    localparam bit JalEn = 1'b0;
`endif
    localparam int QDepth = 4;

    // Behavioural model: a FIFO of fetched words, the fetch address, and whether a request is open.
    logic [31:0] mq_inst[$];
    logic [31:0] mq_pc[$];
    logic [31:0] m_pc;
    bit          m_busy;

    inst_fetcher #(.IQ_DEPTH_LOG(2)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear_up(rob_clear_up),
        .rob_new_pc  (rob_new_pc),
        .pc          (pc),
        .start_fetch (start_fetch),
        .fetch_ready (fetch_ready),
        .inst        (inst),
        .inst_addr   (inst_addr),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] model_next(input logic [31:0] w, input logic [31:0] a);
        int off;
        off = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        if (JalEn && w[6:0] == 7'h6F) return a + off;
        return a + 32'd4;
    endfunction

    function automatic logic [31:0] rand_nonjal();
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], 7'b0010011};
    endfunction

    task automatic model_reset();
        mq_inst.delete();
        mq_pc.delete();
        m_pc   = '0;
        m_busy = 1'b0;
    endtask

    // Advance one clock, update the model from the inputs seen at that edge, settle 1ns past it.
    task automatic tick();
        bit do_start;
        @(posedge clk_in);
        if (!rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                mq_inst.delete();
                mq_pc.delete();
                m_pc   = rob_new_pc;
                m_busy = 1'b0;
            end else begin
                do_start = !m_busy && (mq_pc.size() < QDepth);
                if (mq_pc.size() != 0 && dec_ready) begin
                    void'(mq_inst.pop_front());
                    void'(mq_pc.pop_front());
                end
                if (m_busy && fetch_ready && inst_addr == m_pc) begin
                    mq_inst.push_back(inst);
                    mq_pc.push_back(inst_addr);
                    m_pc   = model_next(inst, inst_addr);
                    m_busy = 1'b0;
                end
                if (do_start) m_busy = 1'b1;
            end
        end
        #1;
    endtask

    task automatic serve(input int lat);
        int guard;
        guard = 0;
        while (start_fetch !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL serve_timeout: start_fetch=%b, expected 1 within 20 cycles", start_fetch);
        end
        repeat (lat) tick();
        fetch_ready = 1'b1;
        inst        = rand_nonjal();
        inst_addr   = m_pc;
        tick();
        fetch_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0; rob_new_pc = '0;
        fetch_ready = 1'b0; inst = '0; inst_addr = '0; dec_ready = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if ({pc, start_fetch, dec_valid, dec_inst, dec_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pc=%h sf=%b dv=%b di=%h dp=%h, expected all zero",
                     pc, start_fetch, dec_valid, dec_inst, dec_pc);
        end
        rst_in = 1'b1;
        tick();
        n_tests++;
        if (start_fetch !== 1'b1 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: sf=%b pc=%h, expected sf=1 pc=0", start_fetch, pc);
        end
    endtask

    task automatic test_first_fetch();
        repeat (3) tick();
        fetch_ready = 1'b1; inst = 32'h0000_0013; inst_addr = 32'h0;
        tick();
        fetch_ready = 1'b0;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_inst !== 32'h13 || pc !== 32'h4
            || start_fetch !== 1'b0) begin
            n_fail++;
            $display("FAIL first_push: dv=%b dp=%h di=%h pc=%h sf=%b, expected 1 0 13 4 0",
                     dec_valid, dec_pc, dec_inst, pc, start_fetch);
        end
        tick();
        n_tests++;
        if (start_fetch !== 1'b1 || pc !== 32'h4) begin
            n_fail++;
            $display("FAIL second_req: sf=%b pc=%h, expected sf=1 pc=4", start_fetch, pc);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) serve(int'($urandom_range(0, 2)));
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (start_fetch !== 1'b0 || dec_pc !== 32'h0 || pc !== 32'h10) begin
                n_fail++;
                $display("FAIL full_hold: sf=%b dp=%h pc=%h, expected sf=0 dp=0 pc=10",
                         start_fetch, dec_pc, pc);
            end
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        n_tests++;
        if (start_fetch !== 1'b0 || dec_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL pop_one: sf=%b dp=%h, expected sf=0 dp=4", start_fetch, dec_pc);
        end
        tick();
        n_tests++;
        if (start_fetch !== 1'b1 || pc !== 32'h10) begin
            n_fail++;
            $display("FAIL refetch_after_pop: sf=%b pc=%h, expected sf=1 pc=10", start_fetch, pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pop;
        exp_pop   = 32'h4;
        dec_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            fetch_ready = m_busy;
            inst        = rand_nonjal();
            inst_addr   = m_pc;
            if (dec_valid === 1'b1) begin
                n_tests++;
                if (dec_pc !== exp_pop) begin
                    n_fail++;
                    $display("FAIL stream_order: dec_pc=%h, expected %h", dec_pc, exp_pop);
                end
                exp_pop = exp_pop + 32'd4;
            end
            tick();
            n_tests++;
            if (pc !== m_pc || start_fetch !== m_busy || dec_valid !== (mq_pc.size() != 0)) begin
                n_fail++;
                $display("FAIL stream_state: pc=%h sf=%b dv=%b, expected pc=%h sf=%b dv=%b",
                         pc, start_fetch, dec_valid, m_pc, m_busy, mq_pc.size() != 0);
            end
        end
        fetch_ready = 1'b0;
    endtask

    task automatic test_flush();
        int guard;
        guard = 0;
        while (start_fetch !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        dec_ready = 1'b0;
        rob_clear_up = 1'b1; rob_new_pc = 32'h100;
        fetch_ready = 1'b1; inst = rand_nonjal(); inst_addr = m_pc;
        tick();
        rob_clear_up = 1'b0; fetch_ready = 1'b0;
        n_tests++;
        if (dec_valid !== 1'b0 || dec_pc !== 32'h0 || dec_inst !== 32'h0 || pc !== 32'h100
            || start_fetch !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: dv=%b dp=%h di=%h pc=%h sf=%b, expected 0 0 0 100 0",
                     dec_valid, dec_pc, dec_inst, pc, start_fetch);
        end
        tick();
        n_tests++;
        if (start_fetch !== 1'b1 || pc !== 32'h100) begin
            n_fail++;
            $display("FAIL flush_req: sf=%b pc=%h, expected sf=1 pc=100", start_fetch, pc);
        end
    endtask

    task automatic test_jal();
        logic [31:0] exp_pc;
        exp_pc = JalEn ? 32'h28 : 32'h24;
        rob_clear_up = 1'b1; rob_new_pc = 32'h20;
        tick();
        rob_clear_up = 1'b0;
        tick();
        fetch_ready = 1'b1; inst = 32'h0080_006F; inst_addr = 32'h20;
        tick();
        fetch_ready = 1'b0;
        n_tests++;
        if (pc !== exp_pc || dec_inst !== 32'h0080_006F || dec_pc !== 32'h20) begin
            n_fail++;
            $display("FAIL jal_next_pc: pc=%h di=%h dp=%h, expected pc=%h di=0080006f dp=20",
                     pc, dec_inst, dec_pc, exp_pc);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        exp_pc = JalEn ? 32'h28 : 32'h24;
        tick();
        rdy_in = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_ready = (i == 1); inst = rand_nonjal(); inst_addr = exp_pc;
            tick();
            n_tests++;
            if (pc !== exp_pc || start_fetch !== 1'b1 || dec_valid !== 1'b1 || dec_pc !== 32'h20) begin
                n_fail++;
                $display("FAIL stall_hold: pc=%h sf=%b dv=%b dp=%h, expected pc=%h sf=1 dv=1 dp=20",
                         pc, start_fetch, dec_valid, dec_pc, exp_pc);
            end
        end
        rdy_in = 1'b1; dec_ready = 1'b0; fetch_ready = 1'b0;
        #3;
        rst_in = 1'b0;
        #1;
        n_tests++;
        if ({pc, start_fetch, dec_valid, dec_inst, dec_pc} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h sf=%b dv=%b di=%h dp=%h, expected all zero",
                     pc, start_fetch, dec_valid, dec_inst, dec_pc);
        end
        model_reset();
        tick();
        #2;
        rst_in = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            rob_clear_up = ($urandom_range(0, 29) == 0);
            r            = $urandom();
            rob_new_pc   = {r[31:2], 2'b00};
            fetch_ready  = ($urandom_range(0, 9) < 4);
            inst_addr    = ($urandom_range(0, 4) != 0) ? m_pc : m_pc + 32'd8;
            r            = $urandom();
            inst         = ($urandom_range(0, 9) == 0) ? {r[31:7], 7'b1101111} : r;
            dec_ready    = $urandom_range(0, 1) == 1;
            tick();
            n_tests++;
            if ({pc, start_fetch, dec_valid, dec_inst, dec_pc} !==
                {m_pc, m_busy, mq_pc.size() != 0,
                 (mq_inst.size() != 0) ? mq_inst[0] : 32'h0,
                 (mq_pc.size() != 0) ? mq_pc[0] : 32'h0}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: pc=%h sf=%b dv=%b di=%h dp=%h, expected pc=%h sf=%b qlen=%0d",
                         i, pc, start_fetch, dec_valid, dec_inst, dec_pc, m_pc, m_busy, mq_pc.size());
            end
        end
        rdy_in = 1'b1; rob_clear_up = 1'b0; fetch_ready = 1'b0; dec_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_fill();
        test_back_to_back();
        test_flush();
        test_jal();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
